// File: rtl/rr_arbiter16_pkg.sv
// Shared constants for the 16-way round-robin arbiter: sizes and FSM encoding.
package rr_arbiter16_pkg;

  localparam int unsigned N_REQ  = 16;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned HOLD_W = 8;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

endpackage

// File: rtl/rr_arbiter16_if.sv
// Requester-array <-> arbiter bundle; "rel" carries the grantee's release strobe.
interface rr_arbiter16_if;
  import rr_arbiter16_pkg::*;

  logic [N_REQ-1:0] req;
  logic             rel;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             timeout;

  modport master (
    output req, rel,
    input  gnt, gnt_idx, gnt_valid, timeout
  );

  modport slave (
    input  req, rel,
    output gnt, gnt_idx, gnt_valid, timeout
  );
endinterface

// File: rtl/rr_arbiter16_onehot_dec4.sv
// 4-to-16 enable decoder: each output is a full index match ANDed with the enable.
module onehot_dec4
  import rr_arbiter16_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [N_REQ-1:0] out
);

  always_comb begin
    out = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      out[i] = en && (idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/rr_arbiter16.sv
// Round-robin arbiter: rotating-priority pick, grant held until release,
// withdrawal or MAX_HOLD timeout; one dead IDLE cycle between grants.
module rr_arbiter16
  import rr_arbiter16_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_arbiter16_if.slave        bus
);

  localparam logic [HOLD_W-1:0] HOLD_LAST =
    (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

  logic              state;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  idx;
  logic [HOLD_W-1:0] hold;
  logic              to_q;
  logic [IDX_W-1:0]  win;
  logic [IDX_W-1:0]  cand;
  logic              found;
  logic              end_rel;
  logic              end_wd;
  logic              end_to;
  logic [N_REQ-1:0]  gnt;

  // First set request scanning upward from ptr, wrapping through 15 -> 0.
  always_comb begin
    win   = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = ptr + IDX_W'(i);
      if (!found && bus.req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    end_rel = bus.rel;
    end_wd  = !bus.req[idx];
    end_to  = (MAX_HOLD != 0) && (hold == HOLD_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      ptr   <= '0;
      idx   <= '0;
      hold  <= '0;
      to_q  <= 1'b0;
    end else begin
      to_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (found) begin
            idx   <= win;
            hold  <= '0;
            state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (end_rel || end_wd || end_to) begin
            state <= ST_IDLE;
            ptr   <= idx + 1'b1;
            to_q  <= end_to && !end_rel && !end_wd;
          end else if (hold != '1) begin
            hold <= hold + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  onehot_dec4 u_dec (
    .idx (idx),
    .en  (state == ST_GRANT),
    .out (gnt)
  );

  assign bus.gnt       = gnt;
  assign bus.gnt_idx   = idx;
  assign bus.gnt_valid = |gnt;
  assign bus.timeout   = to_q;

endmodule

// File: tb/tb_rr_arbiter16.sv
// Self-checking bench for rr_arbiter16 against a tenure-counting reference model.
module tb_rr_arbiter16;
  import rr_arbiter16_pkg::*;

  localparam int unsigned H = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rr_arbiter16_if bus ();

  rr_arbiter16 #(.MAX_HOLD(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: who owns the resource, how many cycles it has held it,
  // where the next search starts and whether a timeout pulse is showing.
  bit m_busy = 0;
  bit m_to   = 0;
  int m_owner = 0;
  int m_ptr   = 0;
  int m_ten   = 0;
  int m_idx   = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit a, b, c;
    if (rst) begin
      m_busy = 0; m_to = 0; m_owner = 0; m_ptr = 0; m_ten = 0; m_idx = 0;
    end else if (!m_busy) begin
      m_to = 0;
      for (int k = 0; k < 16; k++) begin
        if (bus.req[(m_ptr + k) % 16]) begin
          m_busy  = 1;
          m_owner = (m_ptr + k) % 16;
          m_idx   = m_owner;
          m_ten   = 1;
          break;
        end
      end
    end else begin
      a = bus.rel;
      b = !bus.req[m_owner];
      c = (H != 0) && (m_ten == H);
      if (a || b || c) begin
        m_busy = 0;
        m_ptr  = (m_owner + 1) % 16;
        m_to   = c && !a && !b;
      end else begin
        m_ten++;
        m_to = 0;
      end
    end
  endtask

  task automatic step();
    logic [31:0] exp_gnt;
    @(posedge clk);
    model_edge();
    #1;
    exp_gnt = m_busy ? (32'd1 << m_owner) : 32'd0;
    check("gnt", 32'(bus.gnt), exp_gnt);
    check("gnt_idx", 32'(bus.gnt_idx), 32'(m_idx));
    check("gnt_valid", 32'(bus.gnt_valid), 32'(m_busy));
    check("timeout", 32'(bus.timeout), 32'(m_to));
    check("onehot", 32'($countones(bus.gnt)), 32'(m_busy));
  endtask

  // Step until the model grants (bounded), then confirm the DUT chose 'who'.
  task automatic expect_grant(int who, string tag);
    int budget;
    budget = 40;
    do begin
      step();
      budget--;
    end while (!m_busy && budget > 0);
    if (!m_busy) check({tag, "_wait"}, 32'd0, 32'd1);
    else         check(tag, 32'(bus.gnt_idx), 32'(who));
  endtask

  task automatic release_now();
    bus.rel = 1'b1;
    step();
    bus.rel = 1'b0;
    check("dead_cycle", 32'(bus.gnt_valid), 32'd0);
  endtask

  initial begin
    bus.req = '0;
    bus.rel = 1'b0;
    step();
    step();
    rst = 1'b0;
    repeat (10) step();

    // Fairness rotation, continuing round to a grant for 14.
    bus.req = 16'hFFFF;
    for (int i = 0; i <= 30; i++) begin
      expect_grant(i % 16, "rotate");
      release_now();
    end

    // Wrap-around: ptr is 15, so 0 wins before 3.
    bus.req = 16'h0009;
    expect_grant(0, "wrap0");
    release_now();
    expect_grant(3, "wrap3");
    release_now();

    // Timeout: held for exactly H cycles, pulse, then re-grant.
    bus.req = 16'h0020;
    expect_grant(5, "to_grant");
    repeat (H - 1) step();
    check("to_last_cycle", 32'(bus.gnt), 32'h0020);
    step();
    check("to_pulse", 32'(bus.timeout), 32'd1);
    check("to_gnt_low", 32'(bus.gnt), 32'd0);
    step();
    check("to_regrant", 32'(bus.gnt), 32'h0020);

    // Release coinciding with the timeout cycle suppresses the pulse.
    repeat (H - 1) step();
    bus.rel = 1'b1;
    step();
    bus.rel = 1'b0;
    check("rel_at_to_pulse", 32'(bus.timeout), 32'd0);
    check("rel_at_to_gnt", 32'(bus.gnt_valid), 32'd0);

    // Withdrawal by grantee 7 moves the search start to 8.
    bus.req = 16'h0080;
    expect_grant(7, "wd_grant");
    bus.req = 16'h0000;
    step();
    check("wd_drop", 32'(bus.gnt_valid), 32'd0);
    check("wd_no_to", 32'(bus.timeout), 32'd0);
    bus.req = 16'hFFFF;
    expect_grant(8, "wd_next");
    release_now();

    // Reset mid-grant.
    bus.req = 16'h0100;
    expect_grant(8, "rst_grant");
    rst = 1'b1;
    step();
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_to", 32'(bus.timeout), 32'd0);
    rst = 1'b0;
    bus.req = 16'hFFFF;
    expect_grant(0, "rst_first");
    release_now();

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) bus.req = 16'($urandom & $urandom);
      bus.rel = ($urandom_range(3) == 0);
      rst     = ($urandom_range(99) == 0);
      step();
    end
    rst     = 1'b0;
    bus.rel = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
